// File: rtl/fir_coeff_loader.sv
// Coefficient loader: turns a valid/ready coefficient stream into FIR control-register
// writes (CLEAR, one STORE per tap, closing NOP) and stalls the FIR MAC for the whole load.
module fir_coeff_loader #(
  parameter int TAP       = 32,
  parameter int DIM_COEFF = 16,
  parameter int GAP       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           n_taps,
  input  logic [DIM_COEFF-1:0] coeff_in,
  input  logic                 coeff_valid,
  output logic                 coeff_ready,
  output logic                 we_out,
  output logic [31:0]          cr_out,
  output logic                 stall_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_GAP, S_WAIT, S_STO, S_NOP, S_FIN
  } state_t;

  typedef struct packed {
    logic [DIM_COEFF-1:0] coeff;
    logic [7:0]           idx;
    logic [3:0]           op;
    logic [3:0]           rsvd;
  } cr_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_CLR = 4'h1;
  localparam logic [3:0] OP_STO = 4'h2;
  localparam logic [3:0] GAP_M1 = 4'(GAP - 1);
  localparam logic [8:0] TAP_W  = 9'(TAP);

  state_t     state;
  logic [7:0] n_lat;
  logic [7:0] idx;
  logic [3:0] gap_cnt;
  logic       start_ok;
  cr_t        clr_w, sto_w, nop_w;

  assign start_ok  = (n_taps != 8'd0) && ({1'b0, n_taps} <= TAP_W);
  assign stall_out = busy;

  always_comb begin
    clr_w = '{coeff: '0,       idx: 8'd0, op: OP_CLR, rsvd: 4'h0};
    sto_w = '{coeff: coeff_in, idx: idx,  op: OP_STO, rsvd: 4'h0};
    nop_w = '{coeff: '0,       idx: 8'd0, op: OP_NOP, rsvd: 4'h0};
  end

  // Outputs are registered on the transition into the state that owns them,
  // so each state's output is visible during that state's cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      n_lat       <= 8'd0;
      idx         <= 8'd0;
      gap_cnt     <= 4'd0;
      coeff_ready <= 1'b0;
      we_out      <= 1'b0;
      cr_out      <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      we_out <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_lat  <= n_taps;
              idx    <= 8'd0;
              we_out <= 1'b1;
              cr_out <= clr_w;
              busy   <= 1'b1;
              state  <= S_CLR;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CLR: begin
          gap_cnt <= GAP_M1;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) begin
            if (idx < n_lat) begin
              coeff_ready <= 1'b1;
              state       <= S_WAIT;
            end else begin
              we_out <= 1'b1;
              cr_out <= nop_w;
              state  <= S_NOP;
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        S_WAIT: begin
          if (coeff_valid && coeff_ready) begin
            coeff_ready <= 1'b0;
            we_out      <= 1'b1;
            cr_out      <= sto_w;
            state       <= S_STO;
          end
        end
        S_STO: begin
          idx     <= idx + 8'd1;
          gap_cnt <= GAP_M1;
          state   <= S_GAP;
        end
        S_NOP: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_FIN;
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: write traces, handshake timing, illegal starts,
// full 32-tap load into a FIR register model, and reset abort.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  n_taps;
  logic [15:0] coeff_in;
  logic        coeff_valid;
  logic        coeff_ready, we_out, stall_out, busy, done, err;
  logic [31:0] cr_out;

  fir_coeff_loader #(.TAP(32), .DIM_COEFF(16), .GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .n_taps(n_taps),
    .coeff_in(coeff_in), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .we_out(we_out), .cr_out(cr_out), .stall_out(stall_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  int          cyc = 0, hs_cnt = 0, hs_base = 0;
  int          base, qb, dn0, er0, bad;
  int          done_n = 0, err_n = 0, done_cyc = 0;
  int          we_cyc[$];
  logic [31:0] we_cr[$];
  logic [15:0] tab[0:31];
  logic [15:0] fir_c[0:31];

  assign coeff_in = tab[5'(hs_cnt - hs_base)];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (coeff_valid && coeff_ready) hs_cnt <= hs_cnt + 1;
  end

  // Write monitor plus a behavioural model of the FIR coefficient registers.
  always @(negedge clk) begin
    if (we_out) begin
      we_cyc.push_back(cyc);
      we_cr.push_back(cr_out);
      if (cr_out[7:4] == 4'h1)
        for (int i = 0; i < 32; i++) fir_c[i] <= 16'h0;
      else if (cr_out[7:4] == 4'h2)
        fir_c[cr_out[12:8]] <= cr_out[31:16];
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (err) err_n <= err_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start at a negedge; returns at the negedge of relative cycle 1.
  task automatic run_start(input logic [7:0] n);
    n_taps  = n;
    start   = 1'b1;
    base    = cyc;
    qb      = we_cyc.size();
    dn0     = done_n;
    er0     = err_n;
    hs_base = hs_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_we(input string tag, input int i, input int c, input logic [31:0] r);
    chk({tag, "_cyc"}, we_cyc[qb+i] - base, c);
    chk({tag, "_cr"}, we_cr[qb+i], r);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_taps = 8'd0; coeff_valid = 1'b0;
    for (int i = 0; i < 32; i++) tab[i] = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_we", we_out, 0);
    chk("rst_cr", cr_out, 0);
    chk("rst_busy", {busy, stall_out, done, err, coeff_ready}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal 3-tap load
    tab[0] = 16'h1111; tab[1] = 16'h2222; tab[2] = 16'h3333;
    coeff_valid = 1'b1;
    run_start(8'd3);
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      if (!(busy && stall_out)) bad++;
      @(negedge clk);
    end
    chk("nom_busy_window", bad, 0);
    chk("nom_done_c17", done, 1);
    chk("nom_busy_c17", {busy, stall_out}, 0);
    chk("nom_we_count", we_cyc.size() - qb, 5);
    chk_we("nom_clr", 0, 1, 32'h0000_0010);
    chk_we("nom_st0", 1, 5, 32'h1111_0020);
    chk_we("nom_st1", 2, 9, 32'h2222_0120);
    chk_we("nom_st2", 3, 13, 32'h3333_0220);
    chk_we("nom_nop", 4, 16, 32'h0000_0000);
    repeat (3) @(negedge clk);
    chk("nom_done_n", done_n - dn0, 1);
    chk("nom_cr_hold", cr_out, 0);

    // Backpressure before the second coefficient
    run_start(8'd3);
    repeat (4) @(negedge clk);
    coeff_valid = 1'b0;
    repeat (3) @(negedge clk);
    bad = 0;
    for (int k = 8; k <= 17; k++) begin
      if (!(coeff_ready === 1'b1 && we_out === 1'b0)) bad++;
      @(negedge clk);
    end
    chk("bp_ready_held", bad, 0);
    coeff_valid = 1'b1;
    repeat (12) @(negedge clk);
    chk("bp_we_count", we_cyc.size() - qb, 5);
    chk_we("bp_st0", 1, 5, 32'h1111_0020);
    chk_we("bp_st1", 2, 19, 32'h2222_0120);
    chk_we("bp_st2", 3, 23, 32'h3333_0220);
    chk_we("bp_nop", 4, 26, 32'h0000_0000);
    chk("bp_done_cyc", done_cyc - base, 27);

    // start pulses during a load, including the FIN cycle
    run_start(8'd3);
    repeat (2) @(negedge clk);
    start = 1'b1; n_taps = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("sb_busy_after", busy, 0);
    chk("sb_err", err_n - er0, 0);
    chk("sb_we_count", we_cyc.size() - qb, 5);
    chk_we("sb_st1", 2, 9, 32'h2222_0120);
    chk_we("sb_nop", 4, 16, 32'h0000_0000);
    repeat (3) @(negedge clk);

    // Illegal starts
    coeff_valid = 1'b0;
    run_start(8'd0);
    chk("ill0_err", {err, busy}, 2'b10);
    @(negedge clk);
    chk("ill0_err_clr", err, 0);
    run_start(8'd33);
    chk("ill33_err", {err, busy}, 2'b10);
    @(negedge clk);
    chk("ill33_err_clr", err, 0);
    repeat (3) @(negedge clk);
    chk("ill_no_we", we_cyc.size() - qb, 0);
    chk("ill_busy", busy, 0);

    // Full 32-tap load, coeff = index
    for (int i = 0; i < 32; i++) tab[i] = 16'(i);
    coeff_valid = 1'b1;
    run_start(8'd32);
    repeat (140) @(negedge clk);
    chk("full_we_count", we_cyc.size() - qb, 34);
    chk_we("full_clr", 0, 1, 32'h0000_0010);
    chk_we("full_last", 32, 129, 32'h001F_1F20);
    chk_we("full_nop", 33, 132, 32'h0000_0000);
    bad = 0;
    for (int i = 0; i < 32; i++) if (fir_c[i] !== 16'(i)) bad++;
    chk("full_fir_model", bad, 0);
    chk("full_done_n", done_n - dn0, 1);
    chk("full_done_cyc", done_cyc - base, 133);

    // Reset in the WAIT before coefficient 2
    run_start(8'd3);
    repeat (11) @(negedge clk);
    chk("rml_in_wait", coeff_ready, 1);
    rst = 1'b1;
    #1;
    chk("rml_cr", cr_out, 0);
    chk("rml_outs", {we_out, busy, stall_out, done, err, coeff_ready}, 0);
    qb = we_cyc.size();
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rml_no_we", we_cyc.size() - qb, 0);
    run_start(8'd2);
    repeat (16) @(negedge clk);
    chk("rst_rl_we_count", we_cyc.size() - qb, 4);
    chk_we("rst_rl_clr", 0, 1, 32'h0000_0010);
    chk_we("rst_rl_st0", 1, 5, 32'h0000_0020);
    chk_we("rst_rl_st1", 2, 9, 32'h0001_0120);
    chk_we("rst_rl_nop", 3, 12, 32'h0000_0000);
    chk("rst_rl_done", done_n - dn0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Initiator side of the FIR control-register write protocol (we/cr 32-bit word).
- Accepts a coefficient stream over a valid/ready handshake and drives the FIR control port.
- Issues one CLEAR word, then one STORE word per coefficient (tap index 0..n_taps-1), then a closing NOP word.
- Holds the FIR MAC stalled for the whole load, so a filter can be reprogrammed at run time without host sequencing.

Parameters:
- TAP, 32, number of FIR taps; legal index range 0..TAP-1.
- DIM_COEFF, 16, coefficient width; fixed at 16 (occupies cr[31:16]).
- GAP, 2, minimum idle cycles after every we_out pulse before the next one (range 1..15).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only when busy=0.
- n_taps  in  8  number of coefficients to load; latched at start.
- coeff_in  in  DIM_COEFF  coefficient data.
- coeff_valid  in  1  coeff_in valid.
- coeff_ready  out  1  loader accepts coeff_in this cycle.
- we_out  out  1  control-register write strobe to FIR (one-cycle pulse).
- cr_out  out  32  control word to FIR.
- stall_out  out  1  FIR MAC stall request; equals busy.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse, load completed.
- err  out  1  one-cycle pulse, start rejected.

Behaviour:
- Control word format: [31:16] coefficient value; [15:8] tap index; [7:4] opcode; [3:0] = 0.
- Opcodes: 4'h0 NOP, 4'h1 CLEAR, 4'h2 STORE.
- Reset: all outputs 0, cr_out = 0, FSM in IDLE, index = 0, gap counter = 0. Reset asserted mid-load aborts immediately. No further writes occur; the FIR is left partially loaded.
- FSM states: IDLE, CLR, GAP, WAIT, STO, NOP, FIN.
- IDLE:
  - start=1 with 1 <= n_taps <= TAP: latch n_taps, index = 0, go to CLR.
  - start=1 with n_taps = 0 or n_taps > TAP: err=1 for one cycle, stay in IDLE, no write.
- CLR (cycle s+1 for start at cycle s): we_out=1, cr_out=32'h0000_0010. Go to GAP.
- GAP: hold GAP cycles with we_out=0, coeff_ready=0. Then:
  - go to WAIT if index < n_taps;
  - go to NOP if the last STORE has been issued.
- WAIT: coeff_ready=1. On coeff_valid & coeff_ready, register {coeff_in, index, 4'h2, 4'h0} and go to STO. coeff_valid=0 waits indefinitely (busy stays 1).
- STO: we_out=1 with the registered word, one cycle after the handshake. index increments. Go to GAP.
- NOP: we_out=1, cr_out=32'h0. Go to FIN.
- FIN: done=1, busy=0 (same cycle), go to IDLE. A start in the FIN cycle is ignored.
- busy = 1 from the cycle after an accepted start through the NOP cycle.
- start while busy=1 is ignored (no err).
- coeff_ready is never asserted outside WAIT. A coeff_valid outside WAIT is not consumed.
- cr_out holds its last written value between pulses.
- Pulse spacing: consecutive we_out pulses are at least GAP+1 cycles apart.
  - CLR to first STORE is GAP+2 cycles with valid held high.
  - STORE to STORE is GAP+2 cycles with valid held high.
  - Last STORE to NOP is GAP+1 cycles.
- Index width is 8 bits. Since n_taps <= TAP <= 255, the index never wraps.

Test Plan:
- Nominal load, GAP=2, n_taps=3, coeff_valid always 1, coeffs 0x1111/0x2222/0x3333, start at cycle 0. Required response:
  - we_out at cycles 1, 5, 9, 13, 16;
  - cr_out = 0x00000010, 0x11110020, 0x22220120, 0x33330220, 0x00000000 at those cycles;
  - done at cycle 17; busy and stall_out high for cycles 1-16.
- Backpressure: same load, but coeff_valid stays low 10 cycles in WAIT before the second coefficient. Required response: coeff_ready held high; no we_out until valid; STORE index 1 is issued exactly 1 cycle after the handshake.
- Illegal start: n_taps=0, then n_taps=TAP+1 (33). Required response: err pulse 1 cycle each; no we_out; busy stays 0.
- Full load: n_taps=32 with coeff value = index. Required response: 32 STORE words, last one 0x001F1F20; a FIR model shows coeff_r[i]=i; exactly one done.
- Reset mid-load: rst asserted in the WAIT before coefficient 2. Required response: all outputs 0 asynchronously. After release, a new start runs the full sequence beginning with CLEAR.
- start during busy: start pulses while a load is in progress. Required response: ignored; no err; sequence unchanged.
